div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  EX-stage controller sitting directly upstream of the iterative 32-bit divider.
//  - Detects DIV/DIVU in EX and drives the divider's start/annul/operand inputs.
//  - Holds a pipeline stall request until the divider reports ready.
//  - Latches the 64-bit {remainder,quotient} result and presents a one-instruction HI/LO write.
//  - Releases the divider (start low) so it returns to its free state for the next op.
// PARAMETERS
//  DIV_OP      8'b00011010  op_i encoding for signed divide (matches divider DIV_CONTROL)
//  DIVU_OP     8'b00011011  op_i encoding for unsigned divide (matches divider DIVU_CONTROL)
//  TIMEOUT     6'd40        max BUSY cycles waiting for div_ready_i before abort
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  op_i           in   8   ALU op of instruction in EX
//  reg1_i         in   32  dividend (rs)
//  reg2_i         in   32  divisor (rt)
//  flush_i        in   1   pipeline flush / exception; kills in-flight divide
//  stall_i        in   1   downstream (MEM) stall; EX instruction must not advance
//  div_ready_i    in   1   divider result ready
//  div_result_i   in   64  divider result {rem[63:32], quo[31:0]}
//  div_op_o       out  8   op forwarded to divider
//  div_opdata1_o  out  32  divider dividend
//  div_opdata2_o  out  32  divider divisor
//  div_start_o    out  1   divider start (held high until result captured)
//  div_annul_o    out  1   divider annul
//  stallreq_o     out  1   stall request to pipeline controller
//  whilo_o        out  1   HI/LO write enable
//  hi_o           out  32  HI write data (remainder)
//  lo_o           out  32  LO write data (quotient)
//  err_o          out  1   one-cycle pulse: divide aborted by timeout
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE; timeout counter=0; latched hi/lo/operands=0.
//    Outputs are 0 while in IDLE with no div op.
//  - is_div = (op_i==DIV_OP || op_i==DIVU_OP).
//  - FSM states: IDLE, BUSY, DONE.
//  - IDLE:
//    - If is_div && !flush_i: div_start_o=1, stallreq_o=1 (combinational, same cycle).
//    - Operands and op are driven straight from reg1_i/reg2_i/op_i, then latched; next=BUSY, cnt=0.
//    - Otherwise stay IDLE, all outputs 0.
//  - BUSY:
//    - div_start_o=1, stallreq_o=1; operand outputs driven from the latched copies.
//    - div_ready_i=1: latch hi=div_result_i[63:32], lo=div_result_i[31:0]; next=DONE.
//    - Otherwise cnt++. If cnt==TIMEOUT-1: hi=lo=0, err_o=1 for that cycle, next=DONE.
//  - DONE:
//    - div_start_o=0, so the divider drops back to free next edge.
//    - stallreq_o=0, whilo_o=1, hi_o/lo_o = latched values.
//    - stall_i=1: stay DONE, holding whilo_o/hi_o/lo_o and never reissuing.
//    - stall_i=0: next=IDLE.
//  - Back-to-back divides: a new div op in the IDLE cycle right after DONE issues
//    normally, because the divider has returned to free on that edge.
//  - Flush:
//    - div_annul_o = flush_i (combinational) in every state.
//    - flush_i=1 at an edge forces next=IDLE with cnt=0.
//    - During a flush cycle: start=0, whilo_o=0, stallreq_o=0.
//    - Flush dominates ready, timeout and stall_i when they coincide.
//  - rst dominates flush_i.
//  - Divide by zero: no special case here; the divider's fast ready path and zero result are passed through.
//  - Latency: whilo_o asserts exactly 1 cycle after div_ready_i is first sampled high in BUSY.
//  - hi_o/lo_o are don't-care when whilo_o=0 but are driven 0 in IDLE.
// TESTING
//  - DIV 100/7 (signed), divider model: whilo_o=1, hi_o=2, lo_o=14.
//    stallreq_o high from issue cycle until the cycle before whilo_o.
//  - DIV -7/2 signed, then DIVU 0xFFFFFFF9/2 back-to-back:
//    first gives hi=0xFFFFFFFF, lo=0xFFFFFFFD; second gives hi=1, lo=0x7FFFFFFC.
//    Second start asserts the cycle after the first DONE.
//  - DIVU 5/0: ready via the divider's short path; whilo_o=1 with hi=lo=0; no err_o.
//  - flush_i=1 mid-BUSY (cycle 10):
//    div_annul_o=1 that cycle; next cycle IDLE, start=0, whilo_o never asserts.
//  - stall_i=1 for 3 cycles in DONE: whilo_o/hi_o/lo_o held constant for 4 cycles.
//    div_start_o stays 0 and no second issue occurs.
//  - div_ready_i held 0:
//    err_o pulses once, exactly TIMEOUT cycles after issue (counting from the first BUSY cycle).
//    Next cycle whilo_o=1 with hi=lo=0, then return to IDLE.

Source files
------------

// File: rtl/div_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module  : div_issue_ctrl
// Brief   : EX-stage issue/stall/write-back controller for an iterative divider.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_issue_ctrl #(
    parameter logic [7:0] DIV_OP  = 8'b00011010,
    parameter logic [7:0] DIVU_OP = 8'b00011011,
    parameter logic [5:0] TIMEOUT = 6'd40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  op_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic [7:0]  div_op_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [7:0]  op_q,    op_d;
    logic [31:0] opa_q,   opa_d;
    logic [31:0] opb_q,   opb_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic w_is_div;

    assign w_is_div = (op_i == DIV_OP) || (op_i == DIVU_OP);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        div_op_o      = 8'd0;
        div_opdata1_o = 32'd0;
        div_opdata2_o = 32'd0;
        div_start_o   = 1'b0;
        div_annul_o   = flush_i;
        stallreq_o    = 1'b0;
        whilo_o       = 1'b0;
        hi_o          = 32'd0;
        lo_o          = 32'd0;
        err_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Issue cycle: operands go straight through so the divider starts this edge.
                if (w_is_div && !flush_i) begin
                    div_start_o   = 1'b1;
                    stallreq_o    = 1'b1;
                    div_op_o      = op_i;
                    div_opdata1_o = reg1_i;
                    div_opdata2_o = reg2_i;
                    op_d          = op_i;
                    opa_d         = reg1_i;
                    opb_d         = reg2_i;
                    cnt_d         = 6'd0;
                    state_d       = S_BUSY;
                end
            end

            S_BUSY: begin
                div_op_o      = op_q;
                div_opdata1_o = opa_q;
                div_opdata2_o = opb_q;
                if (flush_i) begin
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end else begin
                    div_start_o = 1'b1;
                    stallreq_o  = 1'b1;
                    if (div_ready_i) begin
                        hi_d    = div_result_i[63:32];
                        lo_d    = div_result_i[31:0];
                        state_d = S_DONE;
                    end else if (cnt_q == TIMEOUT - 6'd1) begin
                        hi_d    = 32'd0;
                        lo_d    = 32'd0;
                        err_o   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end

            S_DONE: begin
                // Start is dropped here so the divider is free again by the next IDLE cycle.
                div_op_o      = op_q;
                div_opdata1_o = opa_q;
                div_opdata2_o = opb_q;
                hi_o          = hi_q;
                lo_o          = lo_q;
                if (flush_i) begin
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end else begin
                    whilo_o = 1'b1;
                    if (!stall_i) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 8'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_div_issue_ctrl
// Brief   : Self-checking bench for div_issue_ctrl with a behavioural divider.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_issue_ctrl;

    localparam logic [7:0] C_DIV_OP  = 8'b00011010;
    localparam logic [7:0] C_DIVU_OP = 8'b00011011;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  op_i;
    logic [31:0] reg1_i, reg2_i;
    logic        flush_i, stall_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic [7:0]  div_op_o;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        div_start_o, div_annul_o, stallreq_o, whilo_o, err_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    int whilo_rises = 0;
    int err_pulses = 0;
    logic prev_whilo = 1'b0;
    logic prev_done_cause = 1'b0;
    logic [63:0] exp_q[$];

    int   model_lat = 5;
    bit   no_ready = 1'b0;
    int   mcnt;

    div_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .op_i          (op_i),
        .reg1_i        (reg1_i),
        .reg2_i        (reg2_i),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .div_ready_i   (div_ready_i),
        .div_result_i  (div_result_i),
        .div_op_o      (div_op_o),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .stallreq_o    (stallreq_o),
        .whilo_o       (whilo_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_div(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (op == C_DIV_OP) begin
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    // Behavioural divider: divide-by-zero takes the short path.
    always @(posedge clk) begin
        if (rst || !div_start_o || div_annul_o) begin
            mcnt         <= 0;
            div_ready_i  <= 1'b0;
            div_result_i <= 64'd0;
        end else if (!no_ready) begin
            if (mcnt >= ((div_opdata2_o == 32'd0) ? 0 : model_lat)) begin
                div_ready_i  <= 1'b1;
                div_result_i <= model_div(div_op_o, div_opdata1_o, div_opdata2_o);
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // Scoreboard: each rising whilo_o consumes one expected {hi,lo}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            if (err_o) err_pulses++;
            if (whilo_o && !prev_whilo) begin
                whilo_rises++;
                if (exp_q.size() == 0) begin
                    chk("whilo_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_hi", {32'd0, hi_o}, {32'd0, e[63:32]});
                    chk("sb_lo", {32'd0, lo_o}, {32'd0, e[31:0]});
                    chk("sb_latency", {63'd0, prev_done_cause}, 64'd1);
                end
            end
        end
        prev_whilo      = whilo_o;
        prev_done_cause = div_ready_i || err_o;
    end

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        op_i   = op;
        reg1_i = a;
        reg2_i = b;
        #1;
        chk("issue_start", {63'd0, div_start_o}, 64'd1);
        chk("issue_stallreq", {63'd0, stallreq_o}, 64'd1);
        chk("issue_opd1", {32'd0, div_opdata1_o}, {32'd0, a});
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        op_i   = 8'd0;
        reg1_i = 32'd0;
        reg2_i = 32'd0;
        #1;
        chk("busy_opd2", {32'd0, div_opdata2_o}, {32'd0, b});
        chk("busy_op", {56'd0, div_op_o}, {56'd0, op});
    endtask

    task automatic wait_whilo();
        int n = 0;
        while (!whilo_o && n < 100) begin
            chk("stallreq_held", {63'd0, stallreq_o}, 64'd1);
            @(negedge clk);
            #1;
            n++;
        end
        chk("whilo_seen", {63'd0, whilo_o}, 64'd1);
        chk("whilo_stallreq", {63'd0, stallreq_o}, 64'd0);
        chk("whilo_start", {63'd0, div_start_o}, 64'd0);
    endtask

    initial begin
        int k;
        int r;
        int e0;
        rst     = 1'b1;
        op_i    = 8'd0;
        reg1_i  = 32'd0;
        reg2_i  = 32'd0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_start", {63'd0, div_start_o}, 64'd0);
        chk("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
        chk("rst_whilo", {63'd0, whilo_o}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_opd", {div_opdata1_o, div_opdata2_o}, 64'd0);
        chk("rst_err_annul", {62'd0, err_o, div_annul_o}, 64'd0);

        // DIV 100 / 7
        issue(C_DIV_OP, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        wait_whilo();

        // Back-to-back: DIV -7/2 then DIVU 0xFFFFFFF9/2
        @(negedge clk);
        issue(C_DIV_OP, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_whilo();
        op_i   = C_DIVU_OP;
        reg1_i = 32'hFFFF_FFF9;
        reg2_i = 32'd2;
        #1;
        chk("done_no_start", {63'd0, div_start_o}, 64'd0);
        @(negedge clk);
        issue(C_DIVU_OP, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'd1, 32'h7FFF_FFFC});
        wait_whilo();

        // DIVU 5 / 0
        @(negedge clk);
        e0 = err_pulses;
        issue(C_DIVU_OP, 32'd5, 32'd0, 1'b1, 64'd0);
        wait_whilo();
        chk("div0_no_err", 64'(err_pulses - e0), 64'd0);

        // Flush in BUSY cycle 10
        @(negedge clk);
        model_lat = 20;
        issue(C_DIV_OP, 32'd100, 32'd7, 1'b0, 64'd0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_annul", {63'd0, div_annul_o}, 64'd1);
        chk("flush_start", {63'd0, div_start_o}, 64'd0);
        chk("flush_stallreq", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("postflush_start", {63'd0, div_start_o}, 64'd0);
        chk("postflush_annul", {63'd0, div_annul_o}, 64'd0);
        r = whilo_rises;
        repeat (30) @(negedge clk);
        chk("flush_no_whilo", 64'(whilo_rises - r), 64'd0);
        model_lat = 5;

        // Stall held 3 cycles in DONE
        issue(C_DIV_OP, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        wait_whilo();
        stall_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("stall_whilo", {63'd0, whilo_o}, 64'd1);
            chk("stall_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
            chk("stall_start", {63'd0, div_start_o}, 64'd0);
        end
        stall_i = 1'b0;
        @(negedge clk);
        #1;
        chk("stall_release_whilo", {63'd0, whilo_o}, 64'd0);
        chk("stall_release_start", {63'd0, div_start_o}, 64'd0);

        // Timeout with ready never asserted
        no_ready = 1'b1;
        e0 = err_pulses;
        issue(C_DIV_OP, 32'd9, 32'd3, 1'b1, 64'd0);
        k = 1;
        while (!err_o && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("timeout_cycle", 64'(k), 64'd40);
        chk("timeout_whilo_low", {63'd0, whilo_o}, 64'd0);
        @(negedge clk);
        #1;
        chk("timeout_whilo", {63'd0, whilo_o}, 64'd1);
        chk("timeout_hilo", {hi_o, lo_o}, 64'd0);
        chk("timeout_err_once", {63'd0, err_o}, 64'd0);
        @(negedge clk);
        #1;
        chk("timeout_idle", {63'd0, whilo_o}, 64'd0);
        chk("timeout_pulses", 64'(err_pulses - e0), 64'd1);
        no_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
